twiddle_sequencer_16: RTL and testbench

- Initiator side of the 16-point twiddle ROM. It walks every stage and butterfly of a radix-2 DIT FFT schedule and drives the ROM address for each one.
- It captures the ROM's combinational re/im response and streams the factors to the butterfly datapath over a valid/ready interface.
- It supports inverse-FFT mode (conjugated twiddles) and saturates values that the ROM cannot represent in WIDTH bits.

---
 rtl/twiddle_sequencer_16_if.sv | 16 +
 rtl/twiddle_sequencer_16.sv | 77 +++++++
 tb/tb_twiddle_sequencer_16.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/twiddle_sequencer_16_if.sv
// twiddle_sequencer_16_if: valid/ready twiddle stream from sequencer to butterfly datapath
interface twiddle_sequencer_16_if #(
  parameter int N     = 16,
  parameter int WIDTH = 16
);
  localparam int LOG2N = $clog2(N);
  logic                     tw_valid;
  logic                     tw_ready;
  logic signed [WIDTH-1:0]  tw_re;
  logic signed [WIDTH-1:0]  tw_im;
  logic [$clog2(LOG2N)-1:0] tw_stage;
  logic [LOG2N-2:0]         tw_idx;
  logic                     tw_last;
  modport master (output tw_valid, tw_re, tw_im, tw_stage, tw_idx, tw_last, input tw_ready);
  modport slave  (input tw_valid, tw_re, tw_im, tw_stage, tw_idx, tw_last, output tw_ready);
endinterface

// File: rtl/twiddle_sequencer_16.sv
// twiddle_sequencer_16: walks a radix-2 DIT schedule, addresses the twiddle ROM and streams saturated factors
module twiddle_sequencer_16 #(
  parameter int N     = 16,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    inv,
  output logic [$clog2(N)-2:0]    rom_addr,
  input  logic signed [WIDTH-1:0] rom_re,
  input  logic signed [WIDTH-1:0] rom_im,
  twiddle_sequencer_16_if.master  tw,
  output logic                    busy,
  output logic                    done
);
  localparam int LOG2N = $clog2(N);
  localparam int IW    = LOG2N - 1;
  localparam int SW    = $clog2(LOG2N);
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);
  localparam logic [IW-1:0] LAST_IDX   = '1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t                  state, state_n;
  logic [SW-1:0]           stage;
  logic [IW-1:0]           idx, mask;
  logic                    inv_q, accept, load, final_item, flush_ack;
  logic signed [WIDTH-1:0] re_n, im_n;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_n;
  // cos(0) = +1.0 and -(-1.0) do not fit Q1.(WIDTH-1), so both clip to the largest positive code
  always_comb begin
    mask       = IW'((1 << stage) - 1);
    rom_addr   = (idx & mask) << (IW - int'(stage));
    re_n       = (rom_addr == '0) ? MAXV : rom_re;
    im_n       = !inv_q ? rom_im : (rom_im == MINV) ? MAXV : -rom_im;
    accept     = state == IDLE && start && !done;
    load       = state == RUN && (!tw.tw_valid || tw.tw_ready);
    final_item = stage == LAST_STAGE && idx == LAST_IDX;
    flush_ack  = state == FLUSH && tw.tw_valid && tw.tw_ready;
    state_n    = accept ? RUN : (load && final_item) ? FLUSH : flush_ack ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      stage       <= '0;
      idx         <= '0;
      inv_q       <= 1'b0;
      done        <= 1'b0;
      tw.tw_valid <= 1'b0;
      tw.tw_re    <= '0;
      tw.tw_im    <= '0;
      tw.tw_stage <= '0;
      tw.tw_idx   <= '0;
      tw.tw_last  <= 1'b0;
    end else begin
      done <= flush_ack;
      if (accept) begin
        inv_q <= inv;
        stage <= '0;
        idx   <= '0;
      end
      if (load) begin
        tw.tw_valid <= 1'b1;
        tw.tw_re    <= re_n;
        tw.tw_im    <= im_n;
        tw.tw_stage <= stage;
        tw.tw_idx   <= idx;
        tw.tw_last  <= final_item;
        idx         <= idx + IW'(1);
        if (idx == LAST_IDX) stage <= stage + SW'(1);
      end
      if (flush_ack) tw.tw_valid <= 1'b0;
    end
endmodule

// File: tb/tb_twiddle_sequencer_16.sv
// tb_twiddle_sequencer_16: random-backpressure scoreboard bench against a trigonometric reference model
module tb_twiddle_sequencer_16;
  localparam int N = 16, WIDTH = 16, LOG2N = 4;
  localparam real PI = 3.141592653589793;
  logic clk = 0, rst = 1, start = 0, inv = 0, busy, done;
  logic [2:0] rom_addr;
  logic signed [15:0] rom_re, rom_im;
  logic signed [15:0] rom_re_t [8];
  logic signed [15:0] rom_im_t [8];
  twiddle_sequencer_16_if #(.N(N), .WIDTH(WIDTH)) tw ();
  twiddle_sequencer_16 #(.N(N), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv), .rom_addr(rom_addr),
    .rom_re(rom_re), .rom_im(rom_im), .tw(tw), .busy(busy), .done(done));
  always #5 clk = ~clk;
  typedef struct {int re; int im; int stage; int idx; bit last;} item_t;
  item_t sbq[$];
  int compared = 0, mismatched = 0, hs_count = 0, since_start = 0;
  bit armed = 0, exp_busy = 0, exp_done = 0, prev_stall = 0;
  logic [38:0] prev_out;
  function automatic int rnd(real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction
  function automatic int clamp(int v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction
  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // ROM holds the ideal exp(-j*2*pi*k/N) in Q1.15; cos(0) wraps to -32768 on purpose
  initial for (int k = 0; k < 8; k++) begin
    rom_re_t[k] = 16'(rnd(32768.0 * $cos(2.0 * PI * k / N)));
    rom_im_t[k] = 16'(rnd(-32768.0 * $sin(2.0 * PI * k / N)));
  end
  assign rom_re = rom_re_t[rom_addr];
  assign rom_im = rom_im_t[rom_addr];
  // Stage s uses W_N^k with k = (i mod 2^s) * N/2^(s+1); values clamp to the representable range
  task automatic push_run(bit iv);
    for (int s = 0; s < LOG2N; s++)
      for (int i = 0; i < N / 2; i++) begin
        item_t e;
        int k = (i % (1 << s)) * (N >> (s + 1));
        int im = rnd(-32768.0 * $sin(2.0 * PI * k / N));
        e.re    = clamp(rnd(32768.0 * $cos(2.0 * PI * k / N)));
        e.im    = clamp(iv ? -im : im);
        e.stage = s;
        e.idx   = i;
        e.last  = (s == LOG2N - 1) && (i == N / 2 - 1);
        sbq.push_back(e);
      end
  endtask
  always @(negedge clk) begin : monitor
    item_t e;
    logic [38:0] cur;
    bit nd;
    cur = {tw.tw_valid, tw.tw_re, tw.tw_im, tw.tw_stage, tw.tw_idx, tw.tw_last};
    if (armed) begin
      chk("busy", int'(busy), int'(exp_busy));
      chk("done", int'(done), int'(exp_done));
      if (!exp_busy) chk("idle_valid", int'(tw.tw_valid), 0);
      if (since_start == 1) begin chk("valid_too_early", int'(tw.tw_valid), 0); since_start = 2; end
      else if (since_start == 2) begin chk("first_valid", int'(tw.tw_valid), 1); since_start = 0; end
      if (prev_stall) chk("stall_hold", int'(cur == prev_out), 1);
      if (exp_done) chk("items_left_at_done", sbq.size(), 0);
    end
    prev_stall = tw.tw_valid && !tw.tw_ready;
    prev_out = cur;
    if (rst) begin
      sbq.delete();
      exp_busy = 0; exp_done = 0; since_start = 0; prev_stall = 0;
    end else begin
      nd = 0;
      if (start && !exp_busy && !exp_done) begin
        push_run(inv);
        exp_busy = 1; since_start = 1; hs_count = 0;
      end else if (tw.tw_valid && tw.tw_ready) begin
        hs_count++;
        if (sbq.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_item: got stage %0d idx %0d expected none", tw.tw_stage, tw.tw_idx);
        end else begin
          e = sbq.pop_front();
          chk("tw_re", int'(tw.tw_re), e.re);
          chk("tw_im", int'(tw.tw_im), e.im);
          chk("tw_stage", int'(tw.tw_stage), e.stage);
          chk("tw_idx", int'(tw.tw_idx), e.idx);
          chk("tw_last", int'(tw.tw_last), int'(e.last));
          if (e.stage == 0) chk("stage0_re", int'(tw.tw_re), 32767);
          if (e.stage == 3 && e.idx == 1) chk("s3i1_re", int'(tw.tw_re), 30274);
          if (e.stage == 2 && e.idx == 5) chk("s2i5_re", int'(tw.tw_re), 23170);
          if (e.last) begin exp_busy = 0; nd = 1; end
        end
      end
      exp_done = nd;
    end
  end
  task automatic run(bit iv, bit rnd_ready, bit extra, bit toggle, int rst_at);
    int hold = 0, c;
    bit held = 0, fin = 0;
    @(posedge clk); #1;
    start = 1; inv = iv;
    @(posedge clk); #1;
    start = 0;
    for (c = 1; c < 3000 && !fin; c++) begin
      if (rst_at > 0 && hs_count >= rst_at) begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        return;
      end
      if (rnd_ready && tw.tw_valid && tw.tw_last && !held) begin hold = 5; held = 1; end
      if (hold > 0) begin tw.tw_ready = 0; hold--; end
      else tw.tw_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = extra && (c == 3 || c == 10);
      if (toggle) inv = ~inv;
      @(posedge clk); #1;
      fin = done;
    end
    start = 0;
    if (!fin) begin
      compared++; mismatched++;
      $display("FAIL run_timeout: got no done expected done within 3000 cycles");
    end else if (!rnd_ready) chk("run_cycles", c - 1, 33);
  endtask
  initial begin
    tw.tw_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0; armed = 1;
    @(negedge clk);
    chk("rst_valid", int'(tw.tw_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out", int'({tw.tw_re, tw.tw_im, tw.tw_stage, tw.tw_idx, tw.tw_last, rom_addr}), 0);
    run(0, 0, 0, 0, 0);
    run(1, 0, 0, 0, 0);
    run(0, 1, 0, 0, 0);
    run(1, 1, 0, 0, 0);
    run(0, 0, 1, 0, 0);
    start = 1;
    @(posedge clk); #1 start = 0;
    repeat (4) @(posedge clk);
    #1;
    run(0, 0, 0, 0, 0);
    run(0, 0, 0, 0, 12);
    run(0, 0, 0, 0, 0);
    run(1, 1, 0, 1, 0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
